// File: rtl/mem_access_unit.sv
// MEM stage: forwards ALU results to writeback or runs a stalling data-memory
// handshake with a wait timeout. Define MEM_ALIGN_CHECK_EN to reject unaligned accesses.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic        reg_wen_in,
  input  logic        dmem_alu_in,
  input  logic        mem_wen_in,
  input  logic        jr_in,
  input  logic [4:0]  regd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] wb_data_out,
  output logic        reg_wen_out,
  output logic [4:0]  regd_out,
  output logic        jr_out,
  output logic        stall_out,
  output logic        err_out
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACCESS = 1'b1;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic        state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        store_q, store_d;
  logic        load_q, load_d;
  logic        rwen_lat_q, rwen_lat_d;
  logic        jr_lat_q, jr_lat_d;
  logic [4:0]  regd_lat_q, regd_lat_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_rwen_q, wb_rwen_d;
  logic [4:0]  wb_regd_q, wb_regd_d;
  logic        wb_jr_q, wb_jr_d;
  logic        err_q, err_d;

  logic mem_op;
  logic misalign;
  logic wait_expired;

  assign mem_op = dmem_alu_in | mem_wen_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op & (alu_result_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign wait_expired = (cnt_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    store_d    = store_q;
    load_d     = load_q;
    rwen_lat_d = rwen_lat_q;
    jr_lat_d   = jr_lat_q;
    regd_lat_d = regd_lat_q;
    wb_data_d  = wb_data_q;
    wb_rwen_d  = wb_rwen_q;
    wb_regd_d  = wb_regd_q;
    wb_jr_d    = wb_jr_q;
    err_d      = 1'b0;

    if (state_q == ST_IDLE) begin
      if (misalign) begin
        wb_rwen_d = 1'b0;
        wb_jr_d   = 1'b0;
        err_d     = 1'b1;
      end else if (mem_op) begin
        // A combined load+store request is treated as a store with no writeback
        addr_d     = alu_result_in;
        wdata_d    = store_data_in;
        store_d    = mem_wen_in;
        load_d     = dmem_alu_in & ~mem_wen_in;
        rwen_lat_d = reg_wen_in & ~mem_wen_in;
        jr_lat_d   = jr_in;
        regd_lat_d = regd_in;
        cnt_d      = '0;
        wb_rwen_d  = 1'b0;
        wb_jr_d    = 1'b0;
        state_d    = ST_ACCESS;
      end else begin
        wb_data_d = alu_result_in;
        wb_rwen_d = reg_wen_in;
        wb_regd_d = regd_in;
        wb_jr_d   = jr_in;
      end
    end else begin
      if (dmem_ack) begin
        wb_data_d = load_q ? dmem_rdata : addr_q;
        wb_rwen_d = rwen_lat_q;
        wb_regd_d = regd_lat_q;
        wb_jr_d   = jr_lat_q;
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end else if (wait_expired) begin
        wb_rwen_d = 1'b0;
        wb_jr_d   = 1'b0;
        err_d     = 1'b1;
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end else begin
        wb_rwen_d = 1'b0;
        wb_jr_d   = 1'b0;
        cnt_d     = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      store_q    <= 1'b0;
      load_q     <= 1'b0;
      rwen_lat_q <= 1'b0;
      jr_lat_q   <= 1'b0;
      regd_lat_q <= '0;
      wb_data_q  <= '0;
      wb_rwen_q  <= 1'b0;
      wb_regd_q  <= '0;
      wb_jr_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      store_q    <= store_d;
      load_q     <= load_d;
      rwen_lat_q <= rwen_lat_d;
      jr_lat_q   <= jr_lat_d;
      regd_lat_q <= regd_lat_d;
      wb_data_q  <= wb_data_d;
      wb_rwen_q  <= wb_rwen_d;
      wb_regd_q  <= wb_regd_d;
      wb_jr_q    <= wb_jr_d;
      err_q      <= err_d;
    end
  end

  assign dmem_req   = (state_q == ST_ACCESS);
  assign dmem_we    = dmem_req & store_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  // The completing cycle (ack or timeout) releases the stall so EX/MEM advances
  assign stall_out = rst & ((state_q == ST_ACCESS) ? (~dmem_ack & ~wait_expired)
                                                   : (mem_op & ~misalign));

  assign wb_data_out = wb_data_q;
  assign reg_wen_out = wb_rwen_q;
  assign regd_out    = wb_regd_q;
  assign jr_out      = wb_jr_q;
  assign err_out     = err_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max ACCESS cycles awaiting dmem_ack before abort (range 2..255).
REQ-002 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports from EX/MEM register: alu_result_in in 32 (address or ALU result); store_data_in in 32; reg_wen_in in 1; dmem_alu_in in 1 (1 = load, write back memory data); mem_wen_in in 1 (store); jr_in in 1; regd_in in 5.
REQ-005 SHALL have data-memory ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32; dmem_wdata out 32; dmem_rdata in 32; dmem_ack in 1.
REQ-006 SHALL have writeback ports, all registered: wb_data_out out 32; reg_wen_out out 1; regd_out out 5; jr_out out 1.
REQ-007 SHALL have status ports: stall_out out 1 (combinational, holds EX/MEM); err_out out 1 (registered, one-cycle pulse).

Function
REQ-008 SHALL implement FSM states IDLE and ACCESS; mem op = dmem_alu_in | mem_wen_in.
REQ-009 IDLE, no mem op: SHALL load wb_data_out=alu_result_in, reg_wen_out, regd_out, jr_out at next edge (1-cycle latency); stall_out=0.
REQ-010 IDLE, mem op: stall_out=1 same cycle; next edge latch address, store data, control; drive WB outputs as bubble (reg_wen_out=0, jr_out=0); enter ACCESS.
REQ-011 ACCESS: dmem_req=1, dmem_addr/dmem_wdata/dmem_we stable from latched values every cycle until ack; stall_out = ~dmem_ack; WB outputs bubble while not acked.
REQ-012 ACCESS with dmem_ack: next edge load wb_data_out=dmem_rdata for load (latched ALU result for store), reg_wen_out=latched reg_wen & ~store, regd_out, jr_out; dmem_req drops; return IDLE.
REQ-013 Zero-wait memory (ack in first ACCESS cycle): exactly one stall cycle; WB valid two edges after presentation.
REQ-014 mem_wen_in and dmem_alu_in both high: SHALL perform store only; reg_wen_out forced 0.
REQ-015 dmem_ack while IDLE SHALL be ignored.
REQ-016 Wait counter SHALL clear on ACCESS entry, increment each non-ack ACCESS cycle; on reaching TIMEOUT: drop dmem_req, pulse err_out, issue bubble to WB, release stall_out, return IDLE.
REQ-017 dmem_rdata SHALL be sampled only in the ack cycle.

Reset
REQ-018 On rst low, asynchronously: state=IDLE, counter=0, all registered outputs 0, dmem_req=0, err_out=0.
REQ-019 Reset during ACCESS SHALL abandon the transaction; dmem_req deasserts immediately, no WB write issued.
REQ-020 stall_out SHALL be 0 while rst low.

Configuration
REQ-021 With MEM_ALIGN_CHECK_EN defined: mem op with alu_result_in[1:0]!=0 SHALL not enter ACCESS, SHALL issue bubble to WB, pulse err_out next edge, stall_out=0.
REQ-022 Without MEM_ALIGN_CHECK_EN: no alignment check; address passed unmodified; err_out only from timeout.

Verification
REQ-023 ALU op alu_result_in=0x0000_0010, reg_wen_in=1, regd_in=5 -> next edge wb_data_out=0x10, reg_wen_out=1, regd_out=5, stall_out never high.
REQ-024 Load addr 0x100, ack two cycles after dmem_req, dmem_rdata=0xDEAD_BEEF -> 3 stall cycles, dmem_addr=0x100 throughout, then wb_data_out=0xDEADBEEF, reg_wen_out=1.
REQ-025 Store addr 0x200 data 0x1234 with reg_wen_in=1, zero-wait ack -> dmem_we=1, dmem_wdata=0x1234, one stall cycle, reg_wen_out=0.
REQ-026 Load, never acked, TIMEOUT=4 -> dmem_req high 4 cycles, then err_out pulse, bubble, IDLE; late ack ignored.
REQ-027 rst low during ACCESS -> dmem_req and all outputs 0 without a clock edge; after release, next ALU op completes normally.
REQ-028 MEM_ALIGN_CHECK_EN defined, load addr 0x102 -> no dmem_req, err_out pulse, reg_wen_out=0; undefined -> request issued with dmem_addr=0x102.
